// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-file widths, zero-register index and queue entry type
package wb_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic live;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order result queue with squash-by-address and youngest-live-match lookup
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         head,
  output logic              empty,
  output logic              not_full,
  input  logic              squash,
  input  logic [REG_AW-1:0] squash_addr,
  input  logic [REG_AW-1:0] match_addr,
  output logic              match_hit,
  output logic [DATA_W-1:0] match_data
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] rd_ptr, wr_ptr, idx;
  logic [AW:0] count;
  assign head = mem[rd_ptr];
  assign empty = count == '0;
  assign not_full = count < (AW+1)'(DEPTH);
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (squash && vld[i] && mem[i].addr == squash_addr) mem[i].live <= 1'b0;
    if (push) mem[wr_ptr] <= push_entry;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      vld <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (pop) vld[rd_ptr] <= 1'b0;
      if (push) vld[wr_ptr] <= 1'b1;
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_comb begin
    match_hit = 1'b0;
    match_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (vld[idx] && mem[idx].live && mem[idx].addr == match_addr) begin
        match_hit = 1'b1;
        match_data = mem[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write port shared by ALU (priority) and queued LSU results, with forwarding
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);
  logic alu_wr, lsu_push, pop, head_wr, empty, q_hit;
  logic [DATA_W-1:0] q_data;
  wb_entry_t head, push_entry;
  assign alu_wr = alu_valid && alu_addr != ZERO_REG;
  assign lsu_push = lsu_valid && lsu_ready && lsu_addr != ZERO_REG;
  assign push_entry = '{live: !(alu_wr && alu_addr == lsu_addr), addr: lsu_addr, data: lsu_data};
  assign pop = !empty && (!head.live || !alu_wr);
  assign head_wr = pop && head.live;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .nrst(nrst),
    .push(lsu_push),
    .push_entry(push_entry),
    .pop(pop),
    .head(head),
    .empty(empty),
    .not_full(lsu_ready),
    .squash(alu_wr),
    .squash_addr(alu_addr),
    .match_addr(fwd_addr),
    .match_hit(q_hit),
    .match_data(q_data)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= alu_wr || head_wr;
      if (alu_wr || head_wr) begin
        wr_addr <= alu_wr ? alu_addr : head.addr;
        wr_data <= alu_wr ? alu_data : head.data;
      end
    end
  assign fwd_hit = fwd_addr != ZERO_REG && (q_hit || (wr_en && wr_addr == fwd_addr));
  assign fwd_data = !fwd_hit ? '0 : q_hit ? q_data : wr_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors, corner sequences and random traffic against a queue-based model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic nrst;
  logic alu_valid, lsu_valid, lsu_ready, wr_en, fwd_hit;
  logic [4:0] alu_addr, lsu_addr, wr_addr, fwd_addr;
  logic [31:0] alu_data, lsu_data, wr_data, fwd_data;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .nrst(nrst),
    .alu_valid(alu_valid),
    .alu_addr(alu_addr),
    .alu_data(alu_data),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_addr(lsu_addr),
    .lsu_data(lsu_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .fwd_addr(fwd_addr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data)
  );
  typedef struct {
    logic [4:0] a;
    logic [31:0] d;
    bit live;
  } ent_t;
  ent_t q[$];
  bit m_wen = 1'b0;
  logic [4:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;
  typedef struct {
    logic av;
    logic [4:0] aa;
    logic [31:0] ad;
    logic lv;
    logic [4:0] la;
    logic [31:0] ld;
    logic [4:0] fa;
    logic e_wen;
    logic [4:0] e_wa;
    logic [31:0] e_wd;
    logic e_rdy;
    logic e_hit;
    logic [31:0] e_fd;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic [4:0] fa);
    alu_valid = av;
    alu_addr = aa;
    alu_data = ad;
    lsu_valid = lv;
    lsu_addr = la;
    lsu_data = ld;
    fwd_addr = fa;
  endtask
  task automatic idle(input logic [4:0] fa);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fa);
  endtask
  task automatic model_step();
    bit aw, acc, nw;
    logic [4:0] na;
    logic [31:0] nd;
    ent_t e;
    if (!nrst) begin
      q.delete();
      m_wen = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      return;
    end
    aw = alu_valid && alu_addr != 5'd0;
    acc = lsu_valid && q.size() < DEPTH;
    nw = aw;
    na = alu_addr;
    nd = alu_data;
    if (q.size() > 0 && (!q[0].live || !aw)) begin
      e = q.pop_front();
      if (e.live) begin
        nw = 1'b1;
        na = e.a;
        nd = e.d;
      end
    end
    if (aw) foreach (q[i]) if (q[i].a == alu_addr) q[i].live = 1'b0;
    if (acc && lsu_addr != 5'd0) q.push_back('{lsu_addr, lsu_data, !(aw && lsu_addr == alu_addr)});
    m_wen = nw;
    if (nw) begin
      m_waddr = na;
      m_wdata = nd;
    end
  endtask
  function automatic void m_fwd(input logic [4:0] fa, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d = '0;
    if (fa != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (!hit && q[i].live && q[i].a == fa) begin
          hit = 1'b1;
          d = q[i].d;
        end
      if (!hit && m_wen && m_waddr == fa) begin
        hit = 1'b1;
        d = m_wdata;
      end
    end
  endfunction
  task automatic check_model();
    logic h;
    logic [31:0] d;
    m_fwd(fwd_addr, h, d);
    chk("rnd_wr_en", 32'(wr_en), 32'(m_wen));
    if (m_wen) begin
      chk("rnd_wr_addr", 32'(wr_addr), 32'(m_waddr));
      chk("rnd_wr_data", wr_data, m_wdata);
    end
    chk("rnd_lsu_ready", 32'(lsu_ready), 32'(q.size() < DEPTH));
    chk("rnd_fwd_hit", 32'(fwd_hit), 32'(h));
    chk("rnd_fwd_data", fwd_data, d);
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  5'd5,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7,  32'h11, 5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5'd3,  32'h34,       1'b0, 5'd0,  32'h0,  5'd7,  1'b1, 5'd3,  32'h33,       1'b1, 1'b1, 32'h11};
    vecs[4]  = '{1'b1, 5'd3,  32'h35,       1'b0, 5'd0,  32'h0,  5'd3,  1'b1, 5'd3,  32'h34,       1'b1, 1'b1, 32'h34};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd7,  1'b1, 5'd3,  32'h35,       1'b1, 1'b1, 32'h11};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd7,  1'b1, 5'd7,  32'h11,       1'b1, 1'b1, 32'h11};
    vecs[7]  = '{1'b1, 5'd0,  32'h99,       1'b1, 5'd0,  32'h77, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 5'd12, 32'hC1,       1'b1, 5'd12, 32'hC0, 5'd12, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd12, 1'b1, 5'd12, 32'hC1,       1'b1, 1'b1, 32'hC1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd12, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h0};
    nrst = 1'b0;
    idle(5'd5);
    tick();
    tick();
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    nrst = 1'b1;
    tick();
    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].fa);
      #1;
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_wen));
      if (vecs[i].e_wen) begin
        chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_wa));
        chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].e_wd);
      end
      chk($sformatf("vec%0d_lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_fwd_hit", i), 32'(fwd_hit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].e_fd);
      tick();
    end
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA0, 5'd0);
    #1;
    chk("fill0_ready", 32'(lsu_ready), 32'd1);
    tick();
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd11, 32'hA1, 5'd0);
    #1;
    chk("fill1_ready", 32'(lsu_ready), 32'd1);
    tick();
    drive(1'b1, 5'd1, 32'h102, 1'b0, 5'd0, 32'h0, 5'd0);
    #1;
    chk("full_ready", 32'(lsu_ready), 32'd0);
    tick();
    idle(5'd0);
    #1;
    chk("idle_ready_still_low", 32'(lsu_ready), 32'd0);
    chk("idle_alu_wr_addr", 32'(wr_addr), 32'd1);
    chk("idle_alu_wr_data", wr_data, 32'h102);
    tick();
    #1;
    chk("drain_ready", 32'(lsu_ready), 32'd1);
    chk("drain0_wr_en", 32'(wr_en), 32'd1);
    chk("drain0_wr_addr", 32'(wr_addr), 32'd10);
    chk("drain0_wr_data", wr_data, 32'hA0);
    tick();
    #1;
    chk("drain1_wr_addr", 32'(wr_addr), 32'd11);
    chk("drain1_wr_data", wr_data, 32'hA1);
    tick();
    #1;
    chk("drained_wr_en", 32'(wr_en), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAA, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'h0, 5'd9);
    #1;
    chk("waw_fwd_live", fwd_data, 32'hAA);
    tick();
    idle(5'd9);
    #1;
    chk("waw_wr_en", 32'(wr_en), 32'd1);
    chk("waw_wr_data", wr_data, 32'hBB);
    chk("waw_fwd_dead", fwd_data, 32'hBB);
    tick();
    #1;
    chk("waw_no_second_write", 32'(wr_en), 32'd0);
    chk("waw_ready", 32'(lsu_ready), 32'd1);
    tick();
    drive(1'b1, 5'd1, 32'h200, 1'b1, 5'd4, 32'h1, 5'd0);
    tick();
    drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd4, 32'h2, 5'd0);
    tick();
    drive(1'b1, 5'd1, 32'h202, 1'b0, 5'd0, 32'h0, 5'd4);
    #1;
    chk("young_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("young_fwd_data", fwd_data, 32'h2);
    fwd_addr = 5'd0;
    #1;
    chk("r0_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("r0_fwd_data", fwd_data, 32'd0);
    fwd_addr = 5'd4;
    nrst = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_ready", 32'(lsu_ready), 32'd1);
    chk("midrst_fwd_hit", 32'(fwd_hit), 32'd0);
    tick();
    idle(5'd4);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("postrst_wr_en", 32'(wr_en), 32'd0);
      chk("postrst_ready", 32'(lsu_ready), 32'd1);
      tick();
    end
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
      if (i == 300) begin
        nrst = 1'b0;
        #1;
        chk("rnd_rst_wr_en", 32'(wr_en), 32'd0);
        chk("rnd_rst_ready", 32'(lsu_ready), 32'd1);
        tick();
        nrst = 1'b1;
      end else begin
        #1;
        check_model();
        tick();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, LSU result queue depth (power of two, >=2).
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  sole clock; all state updates on posedge.
- nrst  input  1  reset, asynchronous, active-low.
- alu_valid  input  1  single-cycle ALU result present this cycle; no backpressure.
- alu_addr  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- lsu_valid  input  1  long-latency (load/mul) result offered.
- lsu_ready  output  1  queue can accept; transfer when lsu_valid && lsu_ready.
- lsu_addr  input  5  LSU destination register.
- lsu_data  input  32  LSU result.
- wr_en  output  1  register-file write enable.
- wr_addr  output  5  register-file write address.
- wr_data  output  32  register-file write data.
- fwd_addr  input  5  lookup address from read stage.
- fwd_hit  output  1  fwd_addr has a pending (not yet written) value.
- fwd_data  output  32  youngest pending value for fwd_addr.

Function
REQ-003 SHALL treat alu_valid with alu_addr==0 as no ALU write; r0 is never written, never forwarded.
REQ-004 SHALL treat an accepted LSU result with lsu_addr==0 as consumed and discarded (not enqueued).
REQ-005 SHALL register wr_en/wr_addr/wr_data: ALU result at cycle N -> wr_en=1 at cycle N+1.
REQ-006 SHALL give the ALU absolute priority over the write port; the LSU queue head writes only in cycles with no ALU write.
REQ-007 SHALL hold LSU results in a DEPTH-entry in-order FIFO; accepted at cycle N -> wr_en=1 at N+2 earliest.
REQ-008 SHALL drive lsu_ready = (occupancy < DEPTH) from registered occupancy only, with no combinational dependence on same-cycle dequeue.
REQ-009 SHALL allow enqueue and dequeue in the same cycle, with occupancy unchanged.
REQ-010 SHALL, on an ALU write to address A, mark every live queue entry with address A dead (WAW squash); an LSU result accepted in the same cycle with address A counts as older and enters dead.
REQ-011 SHALL pop a dead head without asserting wr_en, one per cycle, including cycles where the ALU owns the port.
REQ-012 SHALL compute fwd_hit/fwd_data combinationally with priority: youngest live queue entry matching fwd_addr, else the registered write stage when wr_en=1 and wr_addr==fwd_addr; fwd_hit=0 for fwd_addr==0.
REQ-013 SHALL hold fwd_data at 0 when fwd_hit=0.
REQ-014 SHALL wrap read/write pointers modulo DEPTH with no loss at full or at empty.

Reset
REQ-015 SHALL, while nrst=0, clear the queue (all entries invalid, pointers and occupancy 0) and set wr_en=0, wr_addr=0, wr_data=0, so that lsu_ready=1 and fwd_hit=0.
REQ-016 SHALL discard queued and in-flight results on reset asserted mid-operation, with no write after reset release until new input arrives.

Structure
REQ-017 SHALL place the register-address width (5), data width (32) and zero-register index in the shared core package.
REQ-018 SHALL implement the queue as one sub-module wb_fifo (entries carrying addr, data and a live bit, plus a squash-by-address port and a match port), with arbitration and forwarding in wb_arbiter.

Verification
REQ-019 ALU alu_addr=5, alu_data=0xDEADBEEF at cycle 0 -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF at cycle 1 only.
REQ-020 LSU result (addr 7, data 0x11) at cycle 0, ALU valid (addr 3) in cycles 0-2 -> ALU writes at cycles 1-3, LSU write to r7 at cycle 4.
REQ-021 Fill queue with 2 LSU results while ALU busy -> lsu_ready=0 on the next cycle; first ALU-idle cycle dequeues one and lsu_ready returns to 1 the cycle after.
REQ-022 LSU result (addr 9, 0xAA) queued, then ALU (addr 9, 0xBB) -> exactly one write, r9=0xBB; dead entry popped with no wr_en.
REQ-023 Queue holds r4=0x1 (older) and r4=0x2 (younger); fwd_addr=4 -> fwd_hit=1, fwd_data=0x2; fwd_addr=0 -> fwd_hit=0.
REQ-024 nrst pulsed low with 2 entries queued -> wr_en=0, lsu_ready=1 and no writes in the cycles following release.
